spi_flash_seq: RTL and testbench

SPI_FLASH_SEQ -- requirements
Module: spi_flash_seq

---
 rtl/nora_spi_pkg.sv | 44 ++++
 rtl/spi_flash_seq.sv | 179 +++++++++++++++++
 tb/tb_spi_flash_seq.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nora_spi_pkg.sv
// Shared constants for the SPI flash read sequencer.
// State encoding, CONTROL bit layout and default opcode.
package nora_spi_pkg;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WAIT_CPU = 4'd1;
  localparam logic [3:0] S_CS_ON    = 4'd2;
  localparam logic [3:0] S_TX       = 4'd3;
  localparam logic [3:0] S_POLL     = 4'd4;
  localparam logic [3:0] S_RX       = 4'd5;
  localparam logic [3:0] S_OUT      = 4'd6;
  localparam logic [3:0] S_CS_OFF   = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam int CTRL_CS_BIT   = 0;
  localparam int CTRL_BUSY_BIT = 0;

  localparam logic [7:0] CTRL_CS_ON  = 8'(1 << CTRL_CS_BIT);
  localparam logic [7:0] CTRL_CS_OFF = 8'h00;
  localparam logic [7:0] CTRL_BUSYV  = 8'(1 << CTRL_BUSY_BIT);

  localparam logic [7:0] DEF_READ_CMD = 8'h03;

  localparam logic AD_CTRL = 1'b0;
  localparam logic AD_DATA = 1'b1;

  // Header byte n of a read: opcode then address MSB first.
  function automatic logic [7:0] hdr_byte(
    input logic [7:0]  cmd,
    input logic [23:0] a,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    b = cmd;
    case (idx)
      2'd1:    b = a[23:16];
      2'd2:    b = a[15:8];
      2'd3:    b = a[7:0];
      default: b = cmd;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spi_flash_seq.sv
// SPI flash read sequencer sharing an SPI master core with a CPU.
// CPU passes through while idle; a job streams len+1 bytes out.
module spi_flash_seq
  import nora_spi_pkg::*;
#(
  parameter logic [7:0] READ_CMD    = DEF_READ_CMD,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  cpu_d_i,
  input  logic        cpu_wr_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_ad_i,
  output logic [7:0]  cpu_d_o,
  output logic [7:0]  spi_d_o,
  output logic        spi_wr_o,
  output logic        spi_rd_o,
  output logic        spi_ad_o,
  input  logic [7:0]  spi_d_i,
  input  logic        start_i,
  input  logic [23:0] addr_i,
  input  logic [7:0]  len_i,
  output logic [7:0]  rdata_o,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  logic [3:0]    state;
  logic          cpu_cs;
  logic [23:0]   addr_q;
  logic [7:0]    rem;
  logic [2:0]    hdr_idx;
  logic [1:0]    rx_ph;
  logic          pend;
  logic [TW-1:0] poll_cnt;
  logic          err_q;
  logic [7:0]    rdata_q;
  logic          poll_ok;

  assign poll_ok  = pend && !spi_d_i[CTRL_BUSY_BIT];
  assign busy_o   = (state != S_IDLE) && (state != S_DONE);
  assign done_o   = (state == S_DONE);
  assign rvalid_o = (state == S_OUT);
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

  // Sequencer state, job registers and CPU chip-select shadow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cpu_cs   <= 1'b0;
      addr_q   <= '0;
      rem      <= '0;
      hdr_idx  <= '0;
      rx_ph    <= '0;
      pend     <= 1'b0;
      poll_cnt <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (cpu_wr_i && cpu_ad_i == AD_CTRL)
        cpu_cs <= cpu_d_i[CTRL_CS_BIT];
      case (state)
        S_IDLE: if (start_i) begin
          addr_q  <= addr_i;
          rem     <= len_i;
          err_q   <= 1'b0;
          hdr_idx <= '0;
          rx_ph   <= '0;
          state   <= S_WAIT_CPU;
        end
        S_WAIT_CPU: if (!cpu_cs) state <= S_CS_ON;
        S_CS_ON: state <= S_TX;
        S_TX: begin
          hdr_idx  <= hdr_idx + 3'd1;
          pend     <= 1'b0;
          poll_cnt <= '0;
          state    <= S_POLL;
        end
        S_POLL: begin
          poll_cnt <= poll_cnt + TW'(1);
          if (poll_ok) begin
            pend <= 1'b0;
            if (rx_ph != 2'd0 || hdr_idx == 3'd4)
              state <= S_RX;
            else
              state <= S_TX;
          end else if (poll_cnt == TLAST) begin
            err_q <= 1'b1;
            pend  <= 1'b0;
            state <= S_CS_OFF;
          end else begin
            pend <= !pend;
          end
        end
        S_RX: begin
          case (rx_ph)
            2'd0: begin
              rx_ph    <= 2'd1;
              pend     <= 1'b0;
              poll_cnt <= '0;
              state    <= S_POLL;
            end
            2'd1: rx_ph <= 2'd2;
            2'd2: begin
              rdata_q <= spi_d_i;
              rx_ph   <= 2'd0;
              state   <= S_OUT;
            end
            default: rx_ph <= 2'd0;
          endcase
        end
        S_OUT: if (rready_i) begin
          if (rem == 8'd0) begin
            state <= S_CS_OFF;
          end else begin
            rem   <= rem - 8'd1;
            state <= S_RX;
          end
        end
        S_CS_OFF: state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Register-access mux: CPU owns the core only while idle.
  always_comb begin
    spi_d_o  = '0;
    spi_wr_o = 1'b0;
    spi_rd_o = 1'b0;
    spi_ad_o = AD_CTRL;
    cpu_d_o  = '0;
    if (state == S_IDLE) begin
      spi_d_o  = cpu_d_i;
      spi_wr_o = cpu_wr_i;
      spi_rd_o = cpu_rd_i;
      spi_ad_o = cpu_ad_i;
      cpu_d_o  = spi_d_i;
    end else begin
      cpu_d_o = cpu_ad_i ? 8'h00 : CTRL_BUSYV;
      case (state)
        S_CS_ON: begin
          spi_wr_o = 1'b1;
          spi_d_o  = CTRL_CS_ON;
        end
        S_TX: begin
          spi_wr_o = 1'b1;
          spi_ad_o = AD_DATA;
          spi_d_o  = hdr_byte(READ_CMD, addr_q, hdr_idx[1:0]);
        end
        S_POLL: spi_rd_o = !pend;
        S_RX: begin
          if (rx_ph == 2'd0) begin
            spi_wr_o = 1'b1;
            spi_ad_o = AD_DATA;
          end else if (rx_ph == 2'd1) begin
            spi_rd_o = 1'b1;
            spi_ad_o = AD_DATA;
          end
        end
        S_CS_OFF: begin
          spi_wr_o = 1'b1;
          spi_d_o  = CTRL_CS_OFF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq with a behavioural SPI core + flash.
// Expected core writes and stream bytes are queued and popped.
module tb_spi_flash_seq;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  cpu_d_i = '0;
  logic        cpu_wr_i = 1'b0;
  logic        cpu_rd_i = 1'b0;
  logic        cpu_ad_i = 1'b0;
  logic [7:0]  cpu_d_o;
  logic [7:0]  spi_d_o;
  logic        spi_wr_o;
  logic        spi_rd_o;
  logic        spi_ad_o;
  logic [7:0]  spi_d_i;
  logic        start_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [7:0]  len_i = '0;
  logic [7:0]  rdata_o;
  logic        rvalid_o;
  logic        rready_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  spi_flash_seq #(.READ_CMD(8'h03), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_d_i(cpu_d_i), .cpu_wr_i(cpu_wr_i),
    .cpu_rd_i(cpu_rd_i), .cpu_ad_i(cpu_ad_i),
    .cpu_d_o(cpu_d_o),
    .spi_d_o(spi_d_o), .spi_wr_o(spi_wr_o),
    .spi_rd_o(spi_rd_o), .spi_ad_o(spi_ad_o),
    .spi_d_i(spi_d_i),
    .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int acc_cnt = 0;
  int both_cnt = 0;
  int done_cnt = 0;
  int rv_cnt = 0;

  logic [8:0] wq[$];
  logic [7:0] sq[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] flash(input logic [23:0] a);
    return a[7:0] * 8'd3 + a[15:8] + 8'h21;
  endfunction

  // Behavioural SPI core with a read-only flash behind it.
  logic        stuck = 1'b0;
  logic [15:0] m_k;
  logic [3:0]  m_busy;
  logic [7:0]  m_rx;
  logic [23:0] m_addr;
  always @(posedge clk) begin
    if (!resetn) begin
      m_k <= '0; m_busy <= '0; m_rx <= '0;
      m_addr <= '0; spi_d_i <= '0;
    end else begin
      if (m_busy != 0) m_busy <= m_busy - 4'd1;
      if (spi_wr_o && !spi_ad_o && spi_d_o[0]) m_k <= '0;
      if (spi_wr_o && spi_ad_o) begin
        m_busy <= 4'd3;
        m_k <= m_k + 16'd1;
        if (m_k == 1) m_addr[23:16] <= spi_d_o;
        if (m_k == 2) m_addr[15:8] <= spi_d_o;
        if (m_k == 3) m_addr[7:0] <= spi_d_o;
        if (m_k < 4) m_rx <= ~spi_d_o;
        else m_rx <= flash(m_addr + 24'(m_k) - 24'd4);
      end
      if (spi_rd_o)
        spi_d_i <= spi_ad_o ? m_rx
                 : {7'b0, (m_busy != 0) || stuck};
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [9:0] ew;
    logic [8:0] es;
    if (resetn) begin
      if (spi_wr_o || spi_rd_o) acc_cnt++;
      if (spi_wr_o && spi_rd_o) both_cnt++;
      if (done_o) done_cnt++;
      if (rvalid_o) rv_cnt++;
      if (spi_wr_o) begin
        ew = wq.size() != 0 ? {1'b0, wq.pop_front()} : 10'h3FF;
        chk("spi_wr", 32'({1'b0, spi_ad_o, spi_d_o}), 32'(ew));
      end
      if (rvalid_o && rready_i) begin
        es = sq.size() != 0 ? {1'b0, sq.pop_front()} : 9'h1FF;
        chk("rx_byte", 32'({1'b0, rdata_o}), 32'(es));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic ad, input logic [7:0] d,
                        input logic pass);
    cpu_wr_i = 1'b1; cpu_ad_i = ad; cpu_d_i = d;
    if (pass) wq.push_back({ad, d});
    #1;
    chk("cpu_wr_route", 32'(spi_wr_o), 32'(pass));
    tick();
    cpu_wr_i = 1'b0;
  endtask

  task automatic cpu_rd(input logic ad, input logic pass,
                        output logic [7:0] v);
    cpu_rd_i = 1'b1; cpu_ad_i = ad;
    #1;
    chk("cpu_rd_route", 32'(spi_rd_o), 32'(pass));
    v = cpu_d_o;
    tick();
    cpu_rd_i = 1'b0;
  endtask

  task automatic push_job(input logic [23:0] a, input logic [7:0] l);
    wq.push_back(9'h001);
    wq.push_back(9'h103);
    wq.push_back({1'b1, a[23:16]});
    wq.push_back({1'b1, a[15:8]});
    wq.push_back({1'b1, a[7:0]});
    for (int i = 0; i <= int'(l); i++) begin
      wq.push_back(9'h100);
      sq.push_back(flash(a + 24'(i)));
    end
    wq.push_back(9'h000);
  endtask

  task automatic start_job(input logic [23:0] a, input logic [7:0] l);
    start_i = 1'b1; addr_i = a; len_i = l;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int seen;
    seen = 0;
    for (int i = 0; i < maxc && seen == 0; i++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    chk(tag, 32'(seen), 32'd1);
    tick();
  endtask

  initial begin
    logic [7:0] v;
    int d0, a0, r0, bad, hit;

    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_rvalid", 32'(rvalid_o), 0);
    chk("rst_rdata", 32'(rdata_o), 0);
    resetn = 1'b1;
    tick();

    // CPU pass-through while idle
    cpu_wr(1'b0, 8'h01, 1'b1);
    cpu_wr(1'b1, 8'h9F, 1'b1);
    repeat (5) tick();
    cpu_rd(1'b1, 1'b1, v);
    chk("pt_data_rd", 32'(cpu_d_o), 32'h60);
    cpu_wr(1'b0, 8'h00, 1'b1);

    // basic job with same-cycle CPU CONTROL write
    d0 = done_cnt;
    cpu_wr_i = 1'b1; cpu_ad_i = 1'b0; cpu_d_i = 8'h00;
    wq.push_back(9'h000);
    push_job(24'h012345, 8'h02);
    start_i = 1'b1; addr_i = 24'h012345; len_i = 8'h02;
    tick();
    start_i = 1'b0; cpu_wr_i = 1'b0;
    chk("job_busy", 32'(busy_o), 1);
    wait_done("job_done", 500);
    chk("job_done_cnt", 32'(done_cnt - d0), 1);
    chk("job_busy_end", 32'(busy_o), 0);
    chk("job_wq_empty", 32'(wq.size()), 0);
    chk("job_sq_empty", 32'(sq.size()), 0);

    // job held off while CPU owns chip-select
    cpu_wr(1'b0, 8'h01, 1'b1);
    d0 = done_cnt;
    push_job(24'h000010, 8'h00);
    start_job(24'h000010, 8'h00);
    a0 = acc_cnt;
    repeat (20) tick();
    chk("wait_noacc", 32'(acc_cnt - a0), 0);
    chk("wait_busy", 32'(busy_o), 1);
    cpu_rd(1'b0, 1'b0, v);
    chk("busy_ctrl_rd", 32'(v), 32'h01);
    cpu_rd(1'b1, 1'b0, v);
    chk("busy_data_rd", 32'(v), 32'h00);
    cpu_wr(1'b1, 8'hAA, 1'b0);
    cpu_wr(1'b0, 8'h00, 1'b0);
    wait_done("wait_done", 500);
    chk("wait_done_cnt", 32'(done_cnt - d0), 1);

    // consumer stall
    rready_i = 1'b0;
    push_job(24'h00ABCD, 8'h01);
    start_job(24'h00ABCD, 8'h01);
    hit = 0;
    for (int i = 0; i < 200 && hit == 0; i++) begin
      @(negedge clk);
      if (rvalid_o) hit = 1;
    end
    chk("stall_valid", 32'(hit), 1);
    v = rdata_o;
    a0 = acc_cnt;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rvalid_o || rdata_o !== v) bad++;
    end
    chk("stall_stable", 32'(bad), 0);
    chk("stall_noacc", 32'(acc_cnt - a0), 0);
    chk("stall_data", 32'(v), 32'(flash(24'h00ABCD)));
    @(posedge clk); #1;
    rready_i = 1'b1;
    wait_done("stall_done", 500);

    // busy stuck: timeout
    stuck = 1'b1;
    d0 = done_cnt;
    r0 = rv_cnt;
    wq.push_back(9'h001);
    wq.push_back(9'h103);
    wq.push_back(9'h000);
    start_job(24'h000100, 8'h03);
    wait_done("tmo_done", 2 * TMO + 50);
    chk("tmo_err", 32'(err_o), 1);
    chk("tmo_no_rvalid", 32'(rv_cnt - r0), 0);
    chk("tmo_done_cnt", 32'(done_cnt - d0), 1);
    chk("tmo_wq_empty", 32'(wq.size()), 0);
    stuck = 1'b0;
    repeat (5) tick();
    chk("tmo_err_sticky", 32'(err_o), 1);

    // 256-byte job, also clears the error
    push_job(24'hFFFFF0, 8'hFF);
    start_job(24'hFFFFF0, 8'hFF);
    chk("err_clear", 32'(err_o), 0);
    wait_done("big_done", 9000);
    chk("big_sq_empty", 32'(sq.size()), 0);
    chk("big_err", 32'(err_o), 0);

    // reset in the middle of the header
    push_job(24'h123456, 8'h00);
    start_job(24'h123456, 8'h00);
    hit = 0;
    for (int i = 0; i < 20 && hit == 0; i++) begin
      @(negedge clk);
      if (spi_wr_o && spi_ad_o) begin
        resetn = 1'b0;
        hit = 1;
      end
    end
    chk("rst_tx_seen", 32'(hit), 1);
    tick();
    wq.delete();
    sq.delete();
    chk("mid_busy", 32'(busy_o), 0);
    chk("mid_err", 32'(err_o), 0);
    chk("mid_rvalid", 32'(rvalid_o), 0);
    chk("mid_rdata", 32'(rdata_o), 0);
    chk("mid_noacc", 32'(spi_wr_o | spi_rd_o), 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_noacc", 32'(spi_wr_o | spi_rd_o), 0);
    chk("post_done", 32'(done_o), 0);
    cpu_wr(1'b1, 8'h5A, 1'b1);
    repeat (5) tick();
    cpu_rd(1'b1, 1'b1, v);
    chk("post_pt_rd", 32'(cpu_d_o), 32'hA5);

    chk("wr_rd_excl", 32'(both_cnt), 0);
    chk("end_wq_empty", 32'(wq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
